inst_sequencer: RTL
===================

// Module: inst_sequencer
// PURPOSE
// Fetches instructions from the on-chip instruction RAM and issues them one at a time to SYSTOLIC_ARRAY_AXI4_FULL.
// For each instruction: drive the instruction bus, pulse init_inst_pulse, then wait for the array's completion flag.
// Handles HALT/NOP opcodes locally, PC wrap-around, and a per-instruction watchdog.
// Replaces the free-running PROGRAM_COUNTER in the top-level integration.
// PARAMETERS
// INST_BITS     128    instruction width; opcode = instruction[INST_BITS-1 -: OPCODE_BITS]
// OPCODE_BITS   4      opcode field width
// PC_DEPTH      1024   instruction RAM depth (power of 2); PC width = $clog2(PC_DEPTH)
// OP_NOP        4'h0   opcode consumed locally, never issued
// OP_HALT       4'hF   opcode ending the program, never issued
// TIMEOUT       65535  max cycles in EXEC before error; 0 disables the watchdog
// PORTS
// clk              in   1          system clock
// reset_n          in   1          async active-low reset
// start            in   1          pulse; begin execution at start_pc (ignored unless IDLE/DONE/ERROR)
// start_pc         in   PCW        first PC, sampled with start
// abort            in   1          pulse; return to IDLE at next edge from any state
// imem_en          out  1          instruction RAM read enable
// imem_addr        out  PCW        instruction RAM address
// imem_dout        in   INST_BITS  RAM data, valid the cycle after imem_en
// instruction      out  INST_BITS  instruction to the array, held stable from issue until the next issue
// init_inst_pulse  out  1          one-cycle strobe: instruction is valid and must start
// flag             in   1          array completion strobe for the current instruction
// idle_flag        in   1          array idle; issue only when high
// pc               out  PCW        address of the current/last fetched instruction
// busy             out  1          high in FETCH/LATCH/ISSUE/EXEC
// done             out  1          high in DONE (HALT reached)
// error            out  1          high in ERROR (watchdog expired)
// BEHAVIOUR
// - Reset: all outputs 0, instruction = 0, pc = 0, state = IDLE, watchdog = 0.
// - States: IDLE, FETCH, LATCH, ISSUE, EXEC, DONE, ERROR.
// - IDLE/DONE/ERROR + start: pc <= start_pc, go to FETCH; done and error clear on that edge.
// - FETCH: imem_en = 1, imem_addr = pc, go to LATCH (one-cycle RAM latency).
// - LATCH: decode imem_dout.
//   - opcode == OP_HALT -> DONE.
//   - opcode == OP_NOP -> pc <= pc+1, go to FETCH.
//   - otherwise register the word into a holding register -> ISSUE.
// - ISSUE: wait while idle_flag == 0.
//   - When idle_flag == 1: instruction <= holding register, init_inst_pulse = 1 for exactly this cycle, go to EXEC.
// - EXEC: wait for flag, then pc <= pc+1 and go to FETCH.
//   - flag seen in the same cycle as init_inst_pulse is ignored; only flag from the cycle after the pulse onward counts.
// - Pipeline cost: minimum 3 overhead cycles per issued instruction (FETCH, LATCH, ISSUE); NOP costs 2.
// - Wrap-around: pc+1 at PC_DEPTH-1 wraps to 0; no error raised.
// - Watchdog: counter clears on ISSUE->EXEC and increments each EXEC cycle.
//   - If TIMEOUT != 0 and the count reaches TIMEOUT with no flag -> ERROR.
//   - flag in the same cycle as expiry takes priority (normal completion).
// - abort has priority over every other transition, including start.
//   - Effect: go to IDLE; imem_en = 0; init_inst_pulse = 0; done and error cleared; instruction and pc retained.
// - reset_n asserted mid-operation: immediate return to reset values; no pulse or fetch may be emitted while reset_n is low.
// - init_inst_pulse is never asserted on two consecutive cycles and never asserted outside ISSUE.
// - instruction changes only on the ISSUE->EXEC edge.
// TESTING
// - RAM {0:op1 A, 1:op2 B, 2:HALT}, start_pc = 0, flag 5 cycles after each pulse -> A then B issued, one pulse each, done = 1, pc = 2.
// - RAM {0:NOP, 1:NOP, 2:op3 C, 3:HALT} -> exactly one pulse carrying C, issued 7 cycles after start.
// - idle_flag held low 10 cycles in ISSUE -> no pulse until idle_flag rises, then pulse on that same cycle.
// - start_pc = 1023, RAM[1023] = op1, RAM[0] = HALT -> one issue, pc wraps to 0, done = 1.
// - TIMEOUT = 8, flag never returned -> error = 1 exactly 8 cycles after entering EXEC, busy = 0; a new start clears error.
// - abort during EXEC, and reset_n low during LATCH -> IDLE next edge (async for reset), no pulse, outputs match the reset/abort rules.

Source files
------------

// File: rtl/inst_sequencer.sv
// Fetches instructions from the instruction RAM and issues them one at a time to the systolic array.
// Costs 3 overhead cycles per issued op (2 per NOP); stalls in ISSUE while idle_flag is low and in EXEC until flag.
module inst_sequencer #(
  parameter int unsigned            INST_BITS   = 128,
  parameter int unsigned            OPCODE_BITS = 4,
  parameter int unsigned            PC_DEPTH    = 1024,
  parameter logic [OPCODE_BITS-1:0] OP_NOP      = OPCODE_BITS'(4'h0),
  parameter logic [OPCODE_BITS-1:0] OP_HALT     = OPCODE_BITS'(4'hF),
  parameter int unsigned            TIMEOUT     = 65535,
  localparam int unsigned           PCW         = $clog2(PC_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PCW-1:0]       start_pc,
  input  logic                 abort,
  output logic                 imem_en,
  output logic [PCW-1:0]       imem_addr,
  input  logic [INST_BITS-1:0] imem_dout,
  output logic [INST_BITS-1:0] instruction,
  output logic                 init_inst_pulse,
  input  logic                 flag,
  input  logic                 idle_flag,
  output logic [PCW-1:0]       pc,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned    WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_EXEC, S_DONE, S_ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [PCW-1:0]         pc_q, pc_d;
  logic [INST_BITS-1:0]   hold_q, hold_d;
  logic [INST_BITS-1:0]   inst_q, inst_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic [OPCODE_BITS-1:0] opcode;
  logic                   wd_expire;

  assign opcode    = imem_dout[INST_BITS-1 -: OPCODE_BITS];
  assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      hold_q  <= '0;
      inst_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      inst_q  <= inst_d;
      wd_q    <= wd_d;
    end
  end

  // abort outranks every transition, start included; pc and instruction are kept
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    inst_d  = inst_q;
    wd_d    = wd_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            pc_d    = start_pc;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          if (opcode == OP_HALT) begin
            state_d = S_DONE;
          end else if (opcode == OP_NOP) begin
            pc_d    = pc_q + PCW'(1);
            state_d = S_FETCH;
          end else begin
            hold_d  = imem_dout;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (idle_flag) begin
            inst_d  = hold_q;
            wd_d    = '0;
            state_d = S_EXEC;
          end
        end
        // flag is only looked at from EXEC, so a flag coinciding with the pulse is dropped
        S_EXEC: begin
          if (flag) begin
            pc_d    = pc_q + PCW'(1);
            state_d = S_FETCH;
          end else if (wd_expire) begin
            state_d = S_ERROR;
          end else begin
            wd_d = wd_q + WDW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_en         = (state_q == S_FETCH) && !abort;
    init_inst_pulse = (state_q == S_ISSUE) && idle_flag && !abort;
    busy            = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                      (state_q == S_ISSUE) || (state_q == S_EXEC);
    done            = (state_q == S_DONE);
    error           = (state_q == S_ERROR);
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = inst_q;

endmodule
